// File: rtl/fetch_queue_if.sv
// Decode-side handshake bundle of the instruction fetch queue.
// master: queue drives head entry + valid; slave: decode drives ready.
interface fetch_queue_if;
   logic        dec_valid;
   logic        dec_ready;
   logic [31:0] dec_pc;
   logic [31:0] dec_instr;
   logic        dec_pred_taken;
   logic [31:0] dec_pred_target;

   modport master (
      output dec_valid,
      output dec_pc,
      output dec_instr,
      output dec_pred_taken,
      output dec_pred_target,
      input  dec_ready
   );

   modport slave (
      input  dec_valid,
      input  dec_pc,
      input  dec_instr,
      input  dec_pred_taken,
      input  dec_pred_target,
      output dec_ready
   );
endinterface

// File: rtl/fetch_queue.sv
// Instruction fetch queue: request/response capture into an FWFT FIFO.
// Ports: clk/rst, fetch_* + imem_rdata in, flush in, stall/count out, dec (master).
module fetch_queue #(
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       fetch_valid,
   input  logic [31:0]                fetch_pc,
   input  logic                       fetch_pred_taken,
   input  logic [31:0]                fetch_pred_target,
   input  logic [31:0]                imem_rdata,
   input  logic                       flush,
   output logic                       stall,
   output logic [$clog2(DEPTH):0]     count,
   fetch_queue_if.master              dec
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic          req_v;
   logic [31:0]   req_pc;
   logic          req_pt;
   logic [31:0]   req_tgt;

   logic [PW-1:0] head;
   logic [PW-1:0] tail;

   logic [31:0]   pc_q    [DEPTH];
   logic [31:0]   instr_q [DEPTH];
   logic          pt_q    [DEPTH];
   logic [31:0]   tgt_q   [DEPTH];

   logic          push;
   logic          pop;
   logic [CW:0]   occ;

   assign push = req_v && !flush;
   assign pop  = dec.dec_valid && dec.dec_ready && !flush;

   // An outstanding request reserves a slot, so stall depends on
   // registers only and never on dec_ready.
   assign occ   = {1'b0, count} + {{CW{1'b0}}, req_v};
   assign stall = occ >= (CW+1)'(DEPTH);

   assign dec.dec_valid       = count != '0;
   assign dec.dec_pc          = pc_q[head];
   assign dec.dec_instr       = instr_q[head];
   assign dec.dec_pred_taken  = pt_q[head];
   assign dec.dec_pred_target = tgt_q[head];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         req_v   <= 1'b0;
         req_pc  <= '0;
         req_pt  <= 1'b0;
         req_tgt <= '0;
      end else begin
         // A fetch issued alongside flush is wrong-path.
         req_v <= fetch_valid && !flush;
         if (fetch_valid && !flush) begin
            req_pc  <= fetch_pc;
            req_pt  <= fetch_pred_taken;
            req_tgt <= fetch_pred_target;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         pc_q[tail]    <= req_pc;
         instr_q[tail] <= imem_rdata;
         pt_q[tail]    <= req_pt;
         tgt_q[tail]   <= req_tgt;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else if (flush) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         if (push)
            tail <= tail + PW'(1);
         if (pop)
            head <= head + PW'(1);
         unique case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: directed phases plus random
// traffic against a queue-based reference model.
module tb_fetch_queue;

   localparam int DEPTH = 4;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] instr;
      logic        pt;
      logic [31:0] tgt;
   } ent_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        fetch_valid;
   logic [31:0] fetch_pc;
   logic        fetch_pred_taken;
   logic [31:0] fetch_pred_target;
   logic [31:0] imem_rdata;
   logic        flush;
   logic        stall;
   logic [2:0]  count;

   fetch_queue_if dec_if ();

   fetch_queue #(.DEPTH(DEPTH)) dut (
      .clk               (clk),
      .rst               (rst),
      .fetch_valid       (fetch_valid),
      .fetch_pc          (fetch_pc),
      .fetch_pred_taken  (fetch_pred_taken),
      .fetch_pred_target (fetch_pred_target),
      .imem_rdata        (imem_rdata),
      .flush             (flush),
      .stall             (stall),
      .count             (count),
      .dec               (dec_if)
   );

   always #5 clk = ~clk;

   int          n_cmp = 0;
   int          n_bad = 0;

   ent_t        q[$];
   bit          pend_v = 1'b0;
   ent_t        pend;
   logic [31:0] next_pc = '0;
   logic [31:0] prev_pc = '0;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [31:0] instr_of(input logic [31:0] pc);
      return pc ^ 32'hA5A5_0000;
   endfunction

   function automatic bit m_stall();
      return (q.size() + int'(pend_v)) >= DEPTH;
   endfunction

   // Called at a falling edge: check outputs, drive one cycle, update model.
   task automatic step(input bit want, input bit rdy, input bit fl,
                       input logic [31:0] fl_pc, input bit pt,
                       input logic [31:0] tgt);
      bit pop_m;
      bit push_m;
      chk("count", 32'(count), 32'(q.size()));
      chk("stall", 32'(stall), 32'(m_stall()));
      chk("dec_valid", 32'(dec_if.dec_valid), 32'(q.size() != 0));
      if (q.size() != 0) begin
         chk("dec_pc", dec_if.dec_pc, q[0].pc);
         chk("dec_instr", dec_if.dec_instr, q[0].instr);
         chk("dec_pt", 32'(dec_if.dec_pred_taken), 32'(q[0].pt));
         chk("dec_tgt", dec_if.dec_pred_target, q[0].tgt);
      end
      if (pend_v && !fl)
         chk("push_room", 32'(count != 3'(DEPTH)), 32'd1);
      fetch_valid       = want && !m_stall();
      fetch_pc          = next_pc;
      fetch_pred_taken  = pt;
      fetch_pred_target = tgt;
      imem_rdata        = instr_of(prev_pc);
      dec_if.dec_ready  = rdy;
      flush             = fl;
      @(posedge clk);
      pop_m  = (q.size() != 0) && rdy && !fl;
      push_m = pend_v && !fl;
      if (fl) begin
         q.delete();
         pend_v = 1'b0;
      end else begin
         if (pop_m)
            void'(q.pop_front());
         if (push_m)
            q.push_back(pend);
         pend_v = fetch_valid;
         pend   = '{fetch_pc, instr_of(fetch_pc), pt, tgt};
      end
      prev_pc = fetch_pc;
      if (fl)
         next_pc = fl_pc;
      else if (fetch_valid)
         next_pc = next_pc + 32'd4;
      @(negedge clk);
   endtask

   initial begin
      rst               = 1'b1;
      fetch_valid       = 1'b0;
      fetch_pc          = '0;
      fetch_pred_taken  = 1'b0;
      fetch_pred_target = '0;
      imem_rdata        = '0;
      flush             = 1'b0;
      dec_if.dec_ready  = 1'b0;
      #1;
      chk("rst_count", 32'(count), 32'd0);
      chk("rst_stall", 32'(stall), 32'd0);
      chk("rst_valid", 32'(dec_if.dec_valid), 32'd0);
      @(negedge clk);
      rst = 1'b0;

      // Streaming 0x0..0x1C with decode always ready.
      next_pc = 32'h0;
      for (int i = 0; i < 8; i++)
         step(1, 1, 0, 0, 0, 0);
      for (int i = 0; i < 4; i++)
         step(0, 1, 0, 0, 0, 0);

      // Fill until back-pressure, single pop, then drain.
      next_pc = 32'h0;
      for (int i = 0; i < 7; i++)
         step(1, 0, 0, 0, 0, 0);
      chk("fill_count", 32'(count), 32'd4);
      chk("fill_stall", 32'(stall), 32'd1);
      step(1, 1, 0, 0, 0, 0);
      for (int i = 0; i < 3; i++)
         step(1, 0, 0, 0, 0, 0);
      for (int i = 0; i < 12; i++)
         step(1, 1, 0, 0, 0, 0);
      for (int i = 0; i < 6; i++)
         step(0, 1, 0, 0, 0, 0);

      // Flush with two queued entries and a request in flight.
      next_pc = 32'h30;
      for (int i = 0; i < 3; i++)
         step(1, 0, 0, 0, 0, 0);
      next_pc = 32'h40;
      step(1, 0, 1, 32'h100, 0, 0);
      chk("flush_count", 32'(count), 32'd0);
      chk("flush_stall", 32'(stall), 32'd0);
      step(1, 0, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0, 0);
      chk("flush_valid", 32'(dec_if.dec_valid), 32'd1);
      chk("flush_first_pc", dec_if.dec_pc, 32'h100);
      for (int i = 0; i < 6; i++)
         step(0, 1, 0, 0, 0, 0);

      // Prediction pass-through around 0x20.
      step(0, 0, 1, 32'h1C, 0, 0);
      step(1, 0, 0, 0, 0, 0);
      step(1, 0, 0, 0, 1, 32'h80);
      step(1, 0, 0, 0, 0, 0);
      for (int i = 0; i < 5; i++)
         step(0, 1, 0, 0, 0, 0);

      // Asynchronous reset with three entries queued.
      next_pc = 32'h200;
      for (int i = 0; i < 4; i++)
         step(1, 0, 0, 0, 0, 0);
      #2 rst = 1'b1;
      #1;
      chk("arst_count", 32'(count), 32'd0);
      chk("arst_stall", 32'(stall), 32'd0);
      chk("arst_valid", 32'(dec_if.dec_valid), 32'd0);
      q.delete();
      pend_v = 1'b0;
      @(negedge clk);
      rst = 1'b0;

      // Random traffic.
      for (int i = 0; i < 3000; i++)
         step(($urandom % 4) != 0, $urandom % 2 == 1,
              ($urandom % 16) == 0, $urandom & 32'hFFFF_FFFC,
              $urandom % 2 == 1, $urandom);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
